// File: rtl/region_mean_acc.sv
// region_mean_acc: per-frame RGB sums over NUM_REG programmable rectangles, streamed out as saturated means.
// Define REGION_MEAN_ROUND_EN to round the mean half up instead of truncating it.
module region_mean_acc #(
    parameter int H_ACT      = 1920,
    parameter int V_ACT      = 1080,
    parameter int NUM_REG    = 8,
    parameter int CH_W       = 8,
    parameter int COORD_W    = 12,
    parameter int SUM_W      = 28,
    parameter int MEAN_SHIFT = 16,
    localparam int IDX_W     = NUM_REG > 1 ? $clog2(NUM_REG) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sof,
    input  logic               data_en,
    input  logic [3*CH_W-1:0]  data,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [COORD_W-1:0] cfg_x0,
    input  logic [COORD_W-1:0] cfg_x1,
    input  logic [COORD_W-1:0] cfg_y0,
    input  logic [COORD_W-1:0] cfg_y1,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   out_idx,
    output logic [CH_W-1:0]    out_r,
    output logic [CH_W-1:0]    out_g,
    output logic [CH_W-1:0]    out_b,
    output logic               out_last,
    output logic               frame_done,
    output logic               frame_err,
    output logic               overrun
);
    typedef enum logic {IDLE, STREAM} state_t;
    state_t state, state_nx;
    logic [COORD_W-1:0] col, row, pcol, prow;
    logic [COORD_W-1:0] pend [NUM_REG][4];
    logic [COORD_W-1:0] act [NUM_REG][4];
    logic [SUM_W-1:0] acc [NUM_REG][3];
    logic [SUM_W-1:0] bank [NUM_REG][3];
    logic [SUM_W-1:0] nsum [NUM_REG][3];
    logic [CH_W-1:0] mean [3];
    logic [IDX_W-1:0] nidx;
    logic line_end, frame_end, boundary, take_bank, handshake, load_beat;

    assign pcol = sof ? '0 : col;
    assign prow = sof ? '0 : row;
    assign line_end = pcol == COORD_W'(H_ACT - 1);
    assign frame_end = data_en && line_end && prow == COORD_W'(V_ACT - 1);
    assign boundary = data_en && (sof || frame_end);

    for (genvar r = 0; r < NUM_REG; r++) begin : g_reg
        logic [COORD_W-1:0] rc [4];
        logic hit;
        // the sof pixel opens a frame, so it already sees the config copied at that boundary
        for (genvar k = 0; k < 4; k++) begin : g_rc
            assign rc[k] = sof ? pend[r][k] : act[r][k];
        end
        assign hit = pcol >= rc[0] && pcol < rc[1] && prow >= rc[2] && prow < rc[3];
        for (genvar c = 0; c < 3; c++) begin : g_ch
            logic [SUM_W:0] s;
            assign s = (SUM_W+1)'(sof ? {SUM_W{1'b0}} : acc[r][c])
                     + (SUM_W+1)'(hit ? data[(2-c)*CH_W +: CH_W] : {CH_W{1'b0}});
            assign nsum[r][c] = s[SUM_W] ? '1 : s[SUM_W-1:0];
        end
    end

    for (genvar c = 0; c < 3; c++) begin : g_mean
        logic [SUM_W:0] q;
`ifdef REGION_MEAN_ROUND_EN
        assign q = ((SUM_W+1)'(bank[nidx][c]) + ((SUM_W+1)'(1) << (MEAN_SHIFT - 1))) >> MEAN_SHIFT;
`else
        assign q = (SUM_W+1)'(bank[nidx][c]) >> MEAN_SHIFT;
`endif
        assign mean[c] = |q[SUM_W:CH_W] ? '1 : q[CH_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
            frame_done <= 1'b0;
            frame_err <= 1'b0;
            overrun <= 1'b0;
            for (int r = 0; r < NUM_REG; r++) begin
                for (int k = 0; k < 4; k++) begin
                    pend[r][k] <= '0;
                    act[r][k] <= '0;
                end
                for (int c = 0; c < 3; c++) begin
                    acc[r][c] <= '0;
                    bank[r][c] <= '0;
                end
            end
        end else begin
            frame_done <= take_bank;
            frame_err <= data_en && sof && (col != '0 || row != '0);
            overrun <= frame_end && state == STREAM;
            if (data_en) begin
                col <= line_end ? '0 : pcol + 1'b1;
                row <= frame_end ? '0 : line_end ? prow + 1'b1 : prow;
            end
            for (int r = 0; r < NUM_REG; r++) begin
                for (int k = 0; k < 4; k++)
                    if (boundary) act[r][k] <= pend[r][k];
                for (int c = 0; c < 3; c++) begin
                    if (data_en) acc[r][c] <= frame_end ? '0 : nsum[r][c];
                    if (take_bank) bank[r][c] <= nsum[r][c];
                end
            end
            // a write in a boundary cycle lands after the copy above, so it waits for the next boundary
            if (cfg_we && int'(cfg_idx) < NUM_REG) begin
                pend[cfg_idx][0] <= cfg_x0;
                pend[cfg_idx][1] <= cfg_x1;
                pend[cfg_idx][2] <= cfg_y0;
                pend[cfg_idx][3] <= cfg_y1;
            end
        end
    end

    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;

    always_comb state_nx = state == IDLE ? (frame_end ? STREAM : IDLE) : (handshake && out_last ? IDLE : STREAM);

    always_comb begin
        take_bank = frame_end && state == IDLE;
        handshake = out_valid && out_ready;
        load_beat = state == STREAM && (!out_valid || (handshake && !out_last));
        nidx = out_valid ? out_idx + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_idx <= '0;
            out_r <= '0;
            out_g <= '0;
            out_b <= '0;
            out_last <= 1'b0;
        end else if (load_beat) begin
            out_valid <= 1'b1;
            out_idx <= nidx;
            out_r <= mean[0];
            out_g <= mean[1];
            out_b <= mean[2];
            out_last <= nidx == IDX_W'(NUM_REG - 1);
        end else if (handshake) begin
            out_valid <= 1'b0;
            out_last <= 1'b0;
        end
    end
endmodule

// File: tb/tb_region_mean_acc.sv
// tb_region_mean_acc: random frames and regions checked against a whole-frame region-sum reference model.
module tb_region_mean_acc;
    localparam int H = 8, V = 4, NR = 2, CW = 8, CO = 12, SW = 16, MS = 2;
`ifdef REGION_MEAN_ROUND_EN
    localparam int RND_R = 2;
`else
    localparam int RND_R = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sof = 1'b0, data_en = 1'b0, cfg_we = 1'b0, out_ready = 1'b0;
    logic [3*CW-1:0] data = '0;
    logic [0:0] cfg_idx = '0;
    logic [CO-1:0] cfg_x0 = '0, cfg_x1 = '0, cfg_y0 = '0, cfg_y1 = '0;
    logic out_valid, out_last, frame_done, frame_err, overrun;
    logic [0:0] out_idx;
    logic [CW-1:0] out_r, out_g, out_b;

    typedef struct {int idx; int r; int g; int b; logic last;} beat_t;
    beat_t beats[$];
    beat_t mb;
    int vectors = 0, errors = 0, n_done = 0, n_err = 0, n_ovr = 0;
    int pend[NR][4];
    int act[NR][4];
    int fm[NR][3];
    int e1[NR][3];
    logic [23:0] frame[V][H];

    always #5 clk = ~clk;

    region_mean_acc #(.H_ACT(H), .V_ACT(V), .NUM_REG(NR), .CH_W(CW), .COORD_W(CO), .SUM_W(SW), .MEAN_SHIFT(MS)) dut (
        .clk(clk), .rst(rst), .sof(sof), .data_en(data_en), .data(data),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x0(cfg_x0), .cfg_x1(cfg_x1), .cfg_y0(cfg_y0), .cfg_y1(cfg_y1),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_last(out_last),
        .frame_done(frame_done), .frame_err(frame_err), .overrun(overrun));

    always @(posedge clk) begin
        if (!rst) begin
            if (frame_done) n_done++;
            if (frame_err) n_err++;
            if (overrun) n_ovr++;
            if (out_valid && out_ready) begin
                mb.idx = int'(out_idx);
                mb.r = int'(out_r);
                mb.g = int'(out_g);
                mb.b = int'(out_b);
                mb.last = out_last;
                beats.push_back(mb);
            end
        end
    end

    function automatic int sat_mean(input int s);
        int m;
`ifdef REGION_MEAN_ROUND_EN
        m = (s + (1 << (MS - 1))) >> MS;
`else
        m = s >> MS;
`endif
        return m > 255 ? 255 : m;
    endfunction

    function automatic void model_frame();
        for (int i = 0; i < NR; i++)
            for (int c = 0; c < 3; c++) begin
                int s;
                s = 0;
                for (int y = 0; y < V; y++)
                    for (int x = 0; x < H; x++)
                        if (x >= act[i][0] && x < act[i][1] && y >= act[i][2] && y < act[i][3])
                            s += int'(frame[y][x][(2-c)*8 +: 8]);
                fm[i][c] = sat_mean(s > 65535 ? 65535 : s);
            end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_frame(input int mode, input logic [23:0] val);
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                frame[y][x] = mode == 0 ? val : 24'($urandom);
    endtask

    task automatic set_region(input int i, input int x0, input int x1, input int y0, input int y1);
        cfg_we = 1'b1;
        cfg_idx = 1'(i);
        cfg_x0 = CO'(x0);
        cfg_x1 = CO'(x1);
        cfg_y0 = CO'(y0);
        cfg_y1 = CO'(y1);
        tick();
        cfg_we = 1'b0;
        pend[i] = '{x0, x1, y0, y1};
    endtask

    task automatic rand_regions();
        for (int i = 0; i < NR; i++) begin
            int x0, y0;
            x0 = $urandom_range(0, H - 1);
            y0 = $urandom_range(0, V - 1);
            set_region(i, x0, $urandom_range(x0 + 1, H), y0, $urandom_range(y0 + 1, V));
        end
    endtask

    task automatic clear_model_cfg();
        for (int i = 0; i < NR; i++) pend[i] = '{0, 0, 0, 0};
        act = pend;
    endtask

    task automatic send_frame(input int n_pix, input int cfg_at = -1, input int ci = 0,
                              input int c0 = 0, input int c1 = 0, input int c2 = 0, input int c3 = 0);
        act = pend;
        for (int k = 0; k < n_pix; k++) begin
            sof = k == 0;
            data_en = 1'b1;
            data = frame[k / H][k % H];
            if (k == cfg_at) begin
                cfg_we = 1'b1;
                cfg_idx = 1'(ci);
                cfg_x0 = CO'(c0);
                cfg_x1 = CO'(c1);
                cfg_y0 = CO'(c2);
                cfg_y1 = CO'(c3);
            end
            tick();
            cfg_we = 1'b0;
            if (k == cfg_at) pend[ci] = '{c0, c1, c2, c3};
        end
        sof = 1'b0;
        data_en = 1'b0;
        if (n_pix == H * V) begin
            model_frame();
            act = pend;
        end
    endtask

    task automatic wait_beats(input int n, input bit rnd);
        int cyc;
        cyc = 0;
        while (beats.size() < n && cyc < 200) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        vectors++;
        if (beats.size() < n) begin
            errors++;
            $display("FAIL beat_count got %0d need %0d", beats.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({out_valid, out_last, frame_done, frame_err, overrun} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000", {out_valid, out_last, frame_done, frame_err, overrun});
        end
        vectors++;
        if ({out_idx, out_r, out_g, out_b} !== 25'b0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", {out_idx, out_r, out_g, out_b});
        end
        rst = 1'b0;
        clear_model_cfg();
        tick();
    endtask

    task automatic test_basic();
        set_region(0, 0, 2, 0, 2);
        beats.delete();
        n_done = 0;
        out_ready = 1'b1;
        fill_frame(0, 24'h102030);
        send_frame(H * V);
        vectors++;
        if (frame_done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_t1 got done=%b valid=%b want 1/0", frame_done, out_valid);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_idx !== 1'b0 || {out_r, out_g, out_b} !== 24'h102030 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL basic_beat0 got v=%b idx=%0d rgb=%h last=%b want 1/0/102030/0", out_valid, out_idx, {out_r, out_g, out_b}, out_last);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_idx !== 1'b1 || {out_r, out_g, out_b} !== 24'h0 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL basic_beat1 got v=%b idx=%0d rgb=%h last=%b want 1/1/000000/1", out_valid, out_idx, {out_r, out_g, out_b}, out_last);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || beats.size() !== 2) begin
            errors++;
            $display("FAIL basic_end got valid=%b beats=%0d want 0/2", out_valid, beats.size());
        end
        repeat (3) tick();
        vectors++;
        if (n_done !== 1 || beats.size() !== 2) begin
            errors++;
            $display("FAIL basic_once got done=%0d beats=%0d want 1/2", n_done, beats.size());
        end
    endtask

    task automatic test_backpressure();
        beats.delete();
        out_ready = 1'b0;
        send_frame(H * V);
        tick();
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_idx !== 1'b0 || {out_r, out_g, out_b} !== 24'h102030) begin
                errors++;
                $display("FAIL hold_c%0d got v=%b idx=%0d rgb=%h want 1/0/102030", k, out_valid, out_idx, {out_r, out_g, out_b});
            end
            if (k < 4) tick();
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_idx !== 1'b1 || out_last !== 1'b1 || {out_r, out_g, out_b} !== 24'h0) begin
            errors++;
            $display("FAIL hold_next got v=%b idx=%0d last=%b rgb=%h want 1/1/1/0", out_valid, out_idx, out_last, {out_r, out_g, out_b});
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || beats.size() !== 2) begin
            errors++;
            $display("FAIL hold_end got valid=%b beats=%0d want 0/2", out_valid, beats.size());
        end
    endtask

    task automatic test_overrun();
        rand_regions();
        beats.delete();
        n_ovr = 0;
        n_done = 0;
        out_ready = 1'b0;
        fill_frame(1, 0);
        send_frame(H * V);
        e1 = fm;
        fill_frame(1, 0);
        send_frame(H * V);
        tick();
        vectors++;
        if (n_ovr !== 1 || n_done !== 1 || beats.size() !== 0) begin
            errors++;
            $display("FAIL overrun_pulse got ovr=%0d done=%0d beats=%0d want 1/1/0", n_ovr, n_done, beats.size());
        end
        out_ready = 1'b1;
        wait_beats(NR, 1'b0);
        for (int i = 0; i < NR && i < beats.size(); i++) begin
            vectors++;
            if (beats[i].idx !== i || beats[i].r !== e1[i][0] || beats[i].g !== e1[i][1] || beats[i].b !== e1[i][2]) begin
                errors++;
                $display("FAIL overrun_b%0d got idx=%0d rgb=%0d/%0d/%0d want %0d/%0d/%0d", i, beats[i].idx,
                         beats[i].r, beats[i].g, beats[i].b, e1[i][0], e1[i][1], e1[i][2]);
            end
        end
    endtask

    task automatic test_abort();
        rand_regions();
        beats.delete();
        n_err = 0;
        n_done = 0;
        out_ready = 1'b1;
        fill_frame(1, 0);
        send_frame(10);
        fill_frame(1, 0);
        send_frame(H * V);
        tick();
        vectors++;
        if (n_err !== 1 || n_done !== 1) begin
            errors++;
            $display("FAIL abort_pulse got err=%0d done=%0d want 1/1", n_err, n_done);
        end
        wait_beats(NR, 1'b0);
        for (int i = 0; i < NR && i < beats.size(); i++) begin
            vectors++;
            if (beats[i].idx !== i || beats[i].r !== fm[i][0] || beats[i].g !== fm[i][1] || beats[i].b !== fm[i][2]) begin
                errors++;
                $display("FAIL abort_b%0d got idx=%0d rgb=%0d/%0d/%0d want %0d/%0d/%0d", i, beats[i].idx,
                         beats[i].r, beats[i].g, beats[i].b, fm[i][0], fm[i][1], fm[i][2]);
            end
        end
    endtask

    task automatic test_rounding();
        set_region(0, 0, 2, 0, 2);
        set_region(1, 0, 0, 0, 0);
        beats.delete();
        out_ready = 1'b1;
        fill_frame(1, 0);
        frame[0][0][23:16] = 8'd1;
        frame[0][1][23:16] = 8'd1;
        frame[1][0][23:16] = 8'd2;
        frame[1][1][23:16] = 8'd2;
        send_frame(H * V);
        wait_beats(NR, 1'b0);
        vectors++;
        if (beats.size() == 0 || beats[0].r !== RND_R || beats[0].g !== fm[0][1] || beats[0].b !== fm[0][2]) begin
            errors++;
            $display("FAIL round_r got r=%0d g=%0d b=%0d want %0d/%0d/%0d", beats[0].r, beats[0].g, beats[0].b, RND_R, fm[0][1], fm[0][2]);
        end
    endtask

    task automatic test_saturation();
        set_region(0, 0, 8, 0, 1);
        beats.delete();
        fill_frame(0, 24'hFFFFFF);
        send_frame(H * V);
        wait_beats(NR, 1'b0);
        vectors++;
        if (beats.size() == 0 || beats[0].r !== 255 || beats[0].g !== 255 || beats[0].b !== 255) begin
            errors++;
            $display("FAIL sat got rgb=%0d/%0d/%0d want 255/255/255", beats[0].r, beats[0].g, beats[0].b);
        end
    endtask

    task automatic test_cfg_midframe();
        set_region(0, 0, 2, 0, 2);
        set_region(1, 2, 6, 1, 3);
        beats.delete();
        fill_frame(1, 0);
        send_frame(H * V, 12, 0, 4, 8, 2, 4);
        e1 = fm;
        wait_beats(NR, 1'b0);
        for (int i = 0; i < NR && i < beats.size(); i++) begin
            vectors++;
            if (beats[i].r !== e1[i][0] || beats[i].g !== e1[i][1] || beats[i].b !== e1[i][2]) begin
                errors++;
                $display("FAIL cfg_old_b%0d got rgb=%0d/%0d/%0d want %0d/%0d/%0d", i,
                         beats[i].r, beats[i].g, beats[i].b, e1[i][0], e1[i][1], e1[i][2]);
            end
        end
        beats.delete();
        fill_frame(1, 0);
        send_frame(H * V);
        wait_beats(NR, 1'b0);
        for (int i = 0; i < NR && i < beats.size(); i++) begin
            vectors++;
            if (beats[i].r !== fm[i][0] || beats[i].g !== fm[i][1] || beats[i].b !== fm[i][2]) begin
                errors++;
                $display("FAIL cfg_new_b%0d got rgb=%0d/%0d/%0d want %0d/%0d/%0d", i,
                         beats[i].r, beats[i].g, beats[i].b, fm[i][0], fm[i][1], fm[i][2]);
            end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            rand_regions();
            beats.delete();
            fill_frame(1, 0);
            send_frame(H * V);
            wait_beats(NR, 1'b1);
            for (int i = 0; i < NR && i < beats.size(); i++) begin
                vectors++;
                if (beats[i].idx !== i || beats[i].last !== (i == NR - 1) ||
                    beats[i].r !== fm[i][0] || beats[i].g !== fm[i][1] || beats[i].b !== fm[i][2]) begin
                    errors++;
                    $display("FAIL rand_f%0d_b%0d got idx=%0d last=%b rgb=%0d/%0d/%0d want %0d/%0d/%0d", f, i, beats[i].idx,
                             beats[i].last, beats[i].r, beats[i].g, beats[i].b, fm[i][0], fm[i][1], fm[i][2]);
                end
            end
        end
    endtask

    task automatic test_reset_stream();
        beats.delete();
        out_ready = 1'b0;
        fill_frame(1, 0);
        send_frame(H * V);
        tick();
        vectors++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre got valid=%b want 1", out_valid);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || out_idx !== 1'b0 || {out_r, out_g, out_b} !== 24'h0) begin
            errors++;
            $display("FAIL rst_stream got valid=%b idx=%0d rgb=%h want 0/0/0", out_valid, out_idx, {out_r, out_g, out_b});
        end
        rst = 1'b0;
        clear_model_cfg();
        n_done = 0;
        n_err = 0;
        out_ready = 1'b1;
        repeat (10) tick();
        vectors++;
        if (beats.size() !== 0 || out_valid !== 1'b0 || n_done !== 0) begin
            errors++;
            $display("FAIL rst_quiet got beats=%0d valid=%b done=%0d want 0/0/0", beats.size(), out_valid, n_done);
        end
        rand_regions();
        fill_frame(1, 0);
        send_frame(13);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model_cfg();
        rand_regions();
        fill_frame(1, 0);
        send_frame(H * V);
        wait_beats(NR, 1'b0);
        vectors++;
        if (n_err !== 0 || n_done !== 1) begin
            errors++;
            $display("FAIL rst_frame_flags got err=%0d done=%0d want 0/1", n_err, n_done);
        end
        for (int i = 0; i < NR && i < beats.size(); i++) begin
            vectors++;
            if (beats[i].r !== fm[i][0] || beats[i].g !== fm[i][1] || beats[i].b !== fm[i][2]) begin
                errors++;
                $display("FAIL rst_frame_b%0d got rgb=%0d/%0d/%0d want %0d/%0d/%0d", i,
                         beats[i].r, beats[i].g, beats[i].b, fm[i][0], fm[i][1], fm[i][2]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun();
        test_abort();
        test_rounding();
        test_saturation();
        test_cfg_midframe();
        test_random();
        test_reset_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
